// File: rtl/nubus_master.sv
// NuBus master controller: arbitrates with the card ID, issues a single-word transfer and
// returns data/status to the local side. Optional data-phase timeout: NUBUS_MASTER_TIMEOUT_EN.
module nubus_master #(
    parameter int unsigned ARB_SETTLE     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        nub_clkn,
    input  logic        nub_resetn,
    input  logic [3:0]  nub_idn,
    input  logic [3:0]  nub_arbn,
    input  logic        nub_startn,
    input  logic        nub_ackn,
    input  logic        nub_tm1n,
    input  logic        nub_tm0n,
    input  logic [31:0] nub_adn,
    input  logic        cpu_valid,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_done,
    output logic        cpu_error,
    output logic [31:0] cpu_rdata,
    output logic [1:0]  mst_status_o,
    output logic        mst_rqstn_o,
    output logic [3:0]  mst_arbn_o,
    output logic        mst_startn_o,
    output logic        mst_tm1n_o,
    output logic        mst_tm0n_o,
    output logic [31:0] mst_adn_o,
    output logic        mst_ad_oe_o,
    output logic        mst_master_o,
    output logic        mst_timeout_o
);

    typedef enum logic [2:0] {StIdle, StArb, StStart, StData, StDone} state_e;

    localparam logic [7:0] SettleLast = 8'(ARB_SETTLE);

    state_e      state_q;
    logic        busy_q, busy_d;
    logic [7:0]  settle_q;
    logic [29:0] addr_q;
    logic        write_q;
    logic [31:0] wdata_q;
    logic        done_q, error_q;
    logic [31:0] rdata_q;
    logic [1:0]  status_q;
    logic        rqstn_q, startn_q, tm1n_q, tm0n_q, ad_oe_q, master_q;
    logic [3:0]  arbn_q;
    logic [31:0] adn_q;
    logic        timed_out;

    // Word-aligned transfers only; the low address bits are never used.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

`ifdef NUBUS_MASTER_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tcnt_q;
    logic       timeout_q, timed_out_q;
    assign timed_out     = timed_out_q;
    assign mst_timeout_o = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timed_out          = 1'b0;
    assign mst_timeout_o      = 1'b0;
`endif

    // Busy from a sampled START until the matching ACK; ACK takes priority.
    always_comb begin
        busy_d = busy_q;
        if (!nub_ackn) begin
            busy_d = 1'b0;
        end else if (!nub_startn) begin
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge nub_clkn) begin
        if (!nub_resetn) begin
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            settle_q <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            rdata_q  <= '0;
            status_q <= '0;
            rqstn_q  <= 1'b1;
            startn_q <= 1'b1;
            tm1n_q   <= 1'b1;
            tm0n_q   <= 1'b1;
            ad_oe_q  <= 1'b0;
            master_q <= 1'b0;
            arbn_q   <= 4'hF;
            adn_q    <= '1;
`ifdef NUBUS_MASTER_TIMEOUT_EN
            tcnt_q      <= '0;
            timeout_q   <= 1'b0;
            timed_out_q <= 1'b0;
`endif
        end else begin
            busy_q  <= busy_d;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef NUBUS_MASTER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (cpu_valid) begin
                        addr_q   <= cpu_addr[31:2];
                        write_q  <= cpu_write;
                        wdata_q  <= cpu_wdata;
                        settle_q <= '0;
                        rqstn_q  <= 1'b0;
                        arbn_q   <= nub_idn;
                        state_q  <= StArb;
                    end
                end
                StArb: begin
                    arbn_q <= nub_idn;
                    if (busy_d) begin
                        settle_q <= '0;
                    end else if (settle_q == SettleLast) begin
                        // A lost check simply restarts the settle window.
                        settle_q <= '0;
                        if (nub_arbn == nub_idn) begin
                            startn_q <= 1'b0;
                            ad_oe_q  <= 1'b1;
                            adn_q    <= ~{addr_q, 2'b00};
                            tm1n_q   <= ~write_q;
                            tm0n_q   <= 1'b1;
                            rqstn_q  <= 1'b1;
                            arbn_q   <= 4'hF;
                            master_q <= 1'b1;
                            state_q  <= StStart;
                        end
                    end else begin
                        settle_q <= settle_q + 8'd1;
                    end
                end
                StStart: begin
                    startn_q <= 1'b1;
                    tm1n_q   <= 1'b1;
                    tm0n_q   <= 1'b1;
                    ad_oe_q  <= write_q;
                    adn_q    <= write_q ? ~wdata_q : '1;
`ifdef NUBUS_MASTER_TIMEOUT_EN
                    tcnt_q      <= '0;
                    timed_out_q <= 1'b0;
`endif
                    state_q  <= StData;
                end
                StData: begin
                    if (!nub_ackn) begin
                        status_q <= {~nub_tm1n, ~nub_tm0n};
                        if (!write_q) begin
                            rdata_q <= ~nub_adn;
                        end
                        ad_oe_q <= 1'b0;
                        adn_q   <= '1;
                        state_q <= StDone;
                    end
`ifdef NUBUS_MASTER_TIMEOUT_EN
                    else if (tcnt_q == TimeoutLast) begin
                        timeout_q   <= 1'b1;
                        timed_out_q <= 1'b1;
                        ad_oe_q     <= 1'b0;
                        adn_q       <= '1;
                        state_q     <= StDone;
                    end else begin
                        tcnt_q <= tcnt_q + 8'd1;
                    end
`endif
                end
                StDone: begin
                    done_q   <= 1'b1;
                    error_q  <= timed_out | (status_q != 2'b00);
                    master_q <= 1'b0;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cpu_done     = done_q;
    assign cpu_error    = error_q;
    assign cpu_rdata    = rdata_q;
    assign mst_status_o = status_q;
    assign mst_rqstn_o  = rqstn_q;
    assign mst_arbn_o   = arbn_q;
    assign mst_startn_o = startn_q;
    assign mst_tm1n_o   = tm1n_q;
    assign mst_tm0n_o   = tm0n_q;
    assign mst_adn_o    = adn_q;
    assign mst_ad_oe_o  = ad_oe_q;
    assign mst_master_o = master_q;

endmodule

// File: tb/tb_nubus_master.sv
// Directed bench for nubus_master: write, read, lost arbitration, busy bus, timeout, reset.
module tb_nubus_master;

    logic        nub_clkn = 1'b0;
    logic        nub_resetn;
    logic [3:0]  nub_idn, nub_arbn, tb_arbn;
    logic        nub_startn, tb_startn, nub_ackn, nub_tm1n, nub_tm0n;
    logic [31:0] nub_adn;
    logic        cpu_valid, cpu_write;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_done, cpu_error;
    logic [31:0] cpu_rdata;
    logic [1:0]  mst_status_o;
    logic        mst_rqstn_o, mst_startn_o, mst_tm1n_o, mst_tm0n_o;
    logic [3:0]  mst_arbn_o;
    logic [31:0] mst_adn_o;
    logic        mst_ad_oe_o, mst_master_o, mst_timeout_o;

    int checks   = 0;
    int failures = 0;

    always #5 nub_clkn = ~nub_clkn;

    // Wired-AND bus lines: our drive combined with foreign drivers.
    assign nub_arbn   = mst_arbn_o & tb_arbn;
    assign nub_startn = mst_startn_o & tb_startn;

    nubus_master #(
        .ARB_SETTLE    (2),
        .TIMEOUT_CYCLES(8)
    ) u_dut (
        .nub_clkn     (nub_clkn),
        .nub_resetn   (nub_resetn),
        .nub_idn      (nub_idn),
        .nub_arbn     (nub_arbn),
        .nub_startn   (nub_startn),
        .nub_ackn     (nub_ackn),
        .nub_tm1n     (nub_tm1n),
        .nub_tm0n     (nub_tm0n),
        .nub_adn      (nub_adn),
        .cpu_valid    (cpu_valid),
        .cpu_write    (cpu_write),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_done     (cpu_done),
        .cpu_error    (cpu_error),
        .cpu_rdata    (cpu_rdata),
        .mst_status_o (mst_status_o),
        .mst_rqstn_o  (mst_rqstn_o),
        .mst_arbn_o   (mst_arbn_o),
        .mst_startn_o (mst_startn_o),
        .mst_tm1n_o   (mst_tm1n_o),
        .mst_tm0n_o   (mst_tm0n_o),
        .mst_adn_o    (mst_adn_o),
        .mst_ad_oe_o  (mst_ad_oe_o),
        .mst_master_o (mst_master_o),
        .mst_timeout_o(mst_timeout_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge nub_clkn);
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        cpu_valid = 1'b1;
        cpu_write = wr;
        cpu_addr  = addr;
        cpu_wdata = data;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (mst_startn_o && n < 100);
    endtask

    // Slave ACK with status tm={tm1n,tm0n}; returns at the negedge where cpu_done is due.
    task automatic ack_and_done(input logic [1:0] tm, input logic [31:0] rd_adn);
        nub_ackn = 1'b0;
        {nub_tm1n, nub_tm0n} = tm;
        nub_adn = rd_adn;
        step();
        check("done_not_early", {31'd0, cpu_done}, 32'd0);
        nub_ackn = 1'b1;
        {nub_tm1n, nub_tm0n} = 2'b11;
        nub_adn = '1;
        step();
    endtask

    // {rqstn,startn,tm1n,tm0n,oe,master,timeout,done,error,arbn}
    task automatic check_reset_state(input string tag);
        check({tag, "_ctrl"}, {19'd0, mst_rqstn_o, mst_startn_o, mst_tm1n_o, mst_tm0n_o,
              mst_ad_oe_o, mst_master_o, mst_timeout_o, cpu_done, cpu_error, mst_arbn_o},
              32'h0000_1E0F);
        check({tag, "_adn"}, mst_adn_o, 32'hFFFF_FFFF);
        check({tag, "_rdata"}, cpu_rdata, 32'h0);
        check({tag, "_status"}, {30'd0, mst_status_o}, 32'h0);
    endtask

    initial begin
        int n, cnt;
        nub_resetn = 1'b0;
        nub_idn    = 4'h6;  // card ID 9, active-low
        tb_arbn    = 4'hF;
        tb_startn  = 1'b1;
        nub_ackn   = 1'b1;
        nub_tm1n   = 1'b1;
        nub_tm0n   = 1'b1;
        nub_adn    = '1;
        cpu_valid  = 1'b0;
        cpu_write  = 1'b0;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        step();
        step();
        check_reset_state("reset");
        nub_resetn = 1'b1;
        step();

        // Idle-bus write
        issue(1'b1, 32'hF900_0010, 32'hDEAD_BEEF);
        step();
        check("wr_rqst", {31'd0, mst_rqstn_o}, 32'd0);
        check("wr_arb_drive", {28'd0, mst_arbn_o}, 32'h6);
        step();
        step();
        check("wr_no_early_start", {31'd0, mst_startn_o}, 32'd1);
        step();
        check("wr_start", {31'd0, mst_startn_o}, 32'd0);
        check("wr_start_ad", mst_adn_o, ~32'hF900_0010);
        check("wr_start_tm", {30'd0, mst_tm1n_o, mst_tm0n_o}, 32'h1);
        check("wr_start_ctl", {25'd0, mst_ad_oe_o, mst_master_o, mst_rqstn_o, mst_arbn_o},
              32'h7F);
        step();
        check("wr_data_ad", mst_adn_o, ~32'hDEAD_BEEF);
        check("wr_data_ctl", {28'd0, mst_ad_oe_o, mst_tm1n_o, mst_tm0n_o, mst_startn_o},
              32'hF);
        step();
        step();
        ack_and_done(2'b11, '1);
        check("wr_done", {29'd0, cpu_done, cpu_error, mst_master_o}, 32'h4);
        check("wr_status", {30'd0, mst_status_o}, 32'h0);
        cpu_valid = 1'b0;
        step();
        check("wr_done_pulse", {31'd0, cpu_done}, 32'd0);

        // Read
        issue(1'b0, 32'h0000_0107, 32'h0);
        wait_start(n);
        check("rd_latency", n, 32'd4);
        check("rd_start_ad", mst_adn_o, ~32'h0000_0104);
        check("rd_start_tm", {30'd0, mst_tm1n_o, mst_tm0n_o}, 32'h3);
        step();
        check("rd_oe_data1", {31'd0, mst_ad_oe_o}, 32'd0);
        step();
        check("rd_oe_data2", {31'd0, mst_ad_oe_o}, 32'd0);
        ack_and_done(2'b11, ~32'h1234_5678);
        check("rd_rdata", cpu_rdata, 32'h1234_5678);
        check("rd_done", {30'd0, cpu_done, cpu_error}, 32'h2);
        cpu_valid = 1'b0;
        step();
        check("rd_rdata_hold", cpu_rdata, 32'h1234_5678);

        // Lost arbitration: a higher ID holds all ARB lines low
        tb_arbn = 4'h0;
        issue(1'b1, 32'h0000_0200, 32'hA5A5_0F0F);
        cnt = 0;
        repeat (7) begin
            step();
            if (!mst_startn_o) cnt++;
        end
        check("lost_no_start", cnt, 32'd0);
        check("lost_rqst_held", {31'd0, mst_rqstn_o}, 32'd0);
        // Settle count was just restarted: two counting clocks plus the win check
        tb_arbn = 4'hF;
        wait_start(n);
        check("win_latency", n, 32'd3);
        step();
        ack_and_done(2'b11, '1);
        check("win_done", {30'd0, cpu_done, cpu_error}, 32'h2);
        cpu_valid = 1'b0;
        step();

        // Bus busy: foreign START holds the settle count until the foreign ACK
        issue(1'b1, 32'h0000_0300, 32'h0000_0001);
        step();
        tb_startn = 1'b0;
        step();
        tb_startn = 1'b1;
        cnt = 0;
        repeat (6) begin
            step();
            if (!mst_startn_o) cnt++;
        end
        check("busy_no_start", cnt, 32'd0);
        nub_ackn = 1'b0;
        step();
        nub_ackn = 1'b1;
        wait_start(n);
        check("busy_release_latency", n, 32'd2);
        step();
        ack_and_done(2'b01, '1);
        check("busy_status", {30'd0, mst_status_o}, 32'h2);
        check("busy_err_done", {30'd0, cpu_done, cpu_error}, 32'h3);
        cpu_valid = 1'b0;
        step();

`ifdef NUBUS_MASTER_TIMEOUT_EN
        // Timeout: no ACK for TIMEOUT_CYCLES data clocks
        issue(1'b0, 32'h0000_0400, 32'h0);
        wait_start(n);
        step();
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!mst_timeout_o && cnt < 20);
        check("timeout_at", cnt, 32'd8);
        step();
        check("timeout_done", {29'd0, cpu_done, cpu_error, mst_timeout_o}, 32'h6);
        cpu_valid = 1'b0;
        // Bus-level ACK ends the abandoned cycle and frees the busy flag
        nub_ackn = 1'b0;
        step();
        nub_ackn = 1'b1;
        step();
`endif

        // Reset during DATA
        issue(1'b1, 32'h0000_0500, 32'h0000_0077);
        wait_start(n);
        step();
        step();
`ifndef NUBUS_MASTER_TIMEOUT_EN
        cnt = 0;
        repeat (40) begin
            step();
            if (cpu_done) cnt++;
        end
        check("no_completion", cnt, 32'd0);
        check("still_master", {31'd0, mst_master_o}, 32'd1);
`endif
        nub_resetn = 1'b0;
        cpu_valid  = 1'b0;
        step();
        check_reset_state("mid_reset");
        nub_resetn = 1'b1;
        cnt = 0;
        repeat (4) begin
            step();
            if (cpu_done) cnt++;
        end
        check("no_done_after_reset", cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
